// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: ALU operation codes, forwarding source select
// and the ID/EX control bundle.
package riscv_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_EQ    = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_NE    = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_GE    = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_LUI   = 4'b1101;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                src_a_pc;
        logic                src_b_imm;
        logic [ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// Combinational bypass selection for one EX source register: EX/MEM result
// beats MEM/WB result, and x0 is never bypassed.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic [REG_ADDR-1:0]   rs,
    input  logic [REG_ADDR-1:0]   mem_rd,
    input  logic                  mem_reg_write,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [REG_ADDR-1:0]   wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output fwd_sel_t              sel,
    output logic [DATA_WIDTH-1:0] value
);

    always_comb begin
        // NOTE: both outputs get a default first so every path assigns them and no latch is inferred.
        sel   = FWD_NONE;
        value = '0;
        if (rs != '0) begin
            if (mem_reg_write && (mem_rd == rs)) begin
                sel   = FWD_MEM;
                value = mem_result;
            end else if (wb_reg_write && (wb_rd == rs)) begin
                sel   = FWD_WB;
                value = wb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard
// detection, driving the ALU operands and operation code.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = ALU_OP_W,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_src_a_pc,
    input  logic                     id_src_b_imm,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     flush,
    input  logic [REG_ADDR-1:0]      mem_rd,
    input  logic                     mem_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [REG_ADDR-1:0]      wb_rd,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     stall_if_id,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_store_data
);

    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [REG_ADDR-1:0]   ex_rs1;
    logic [REG_ADDR-1:0]   ex_rs2;
    id_ex_ctrl_t           ex_ctrl;

    logic                  hazard;
    fwd_sel_t              sel_a;
    fwd_sel_t              sel_b;
    logic [DATA_WIDTH-1:0] bypass_a;
    logic [DATA_WIDTH-1:0] bypass_b;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    // A load in EX cannot bypass its data yet; the dependent ID instruction waits one cycle.
    assign hazard = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign stall_if_id = hazard && !flush;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset || flush || hazard) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= '{reg_write: id_reg_write, mem_read: id_mem_read,
                             mem_write: id_mem_write, src_a_pc: id_src_a_pc,
                             src_b_imm: id_src_b_imm, alu_op: id_alu_op};
        end
    end

    forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR(REG_ADDR)) u_fwd_a (
        .rs(ex_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .sel(sel_a), .value(bypass_a)
    );

    forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR(REG_ADDR)) u_fwd_b (
        .rs(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .sel(sel_b), .value(bypass_b)
    );

    assign fwd_a = (sel_a == FWD_NONE) ? ex_rs1_data : bypass_a;
    assign fwd_b = (sel_b == FWD_NONE) ? ex_rs2_data : bypass_b;

    assign SrcA          = ex_ctrl.src_a_pc  ? ex_pc  : fwd_a;
    assign SrcB          = ex_ctrl.src_b_imm ? ex_imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign Operation     = ex_ctrl.alu_op;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed corner sequences,
// a forwarding vector table, and randomized traffic against a reference model.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        stall_if_id;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_if_id(stall_if_id), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        bit        valid;
        bit [31:0] pc, a_data, b_data, imm;
        bit [4:0]  rs1, rs2, rd;
        bit [3:0]  op;
        bit        a_pc, b_imm, rw, mr, mw;
    } ex_t;

    ex_t m;

    function automatic bit load_use();
        return m.valid && m.mr && (m.rd != 0) && (id_valid === 1'b1) &&
               ((m.rd == id_rs1) || (m.rd == id_rs2));
    endfunction

    function automatic ex_t next_ex();
        ex_t e;
        e = '{default: 0};
        if (!(reset || flush || load_use())) begin
            e.valid = id_valid;  e.pc = id_pc;  e.a_data = id_rs1_data;
            e.b_data = id_rs2_data;  e.imm = id_imm;
            e.rs1 = id_rs1;  e.rs2 = id_rs2;  e.rd = id_rd;  e.op = id_alu_op;
            e.a_pc = id_src_a_pc;  e.b_imm = id_src_b_imm;
            e.rw = id_reg_write;  e.mr = id_mem_read;  e.mw = id_mem_write;
        end
        return e;
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] reg_val);
        if (rs == 0) return reg_val;
        if (mem_reg_write && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd == rs) return wb_result;
        return reg_val;
    endfunction

    task automatic tick();
        ex_t nxt;
        nxt = next_ex();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic check_model(input string tag);
        bit [31:0] fa, fb;
        #1;
        fa = operand(m.rs1, m.a_data);
        fb = operand(m.rs2, m.b_data);
        check({tag, ".SrcA"},       SrcA,          m.a_pc ? m.pc : fa);
        check({tag, ".SrcB"},       SrcB,          m.b_imm ? m.imm : fb);
        check({tag, ".store"},      ex_store_data, fb);
        check({tag, ".Operation"},  {28'd0, Operation}, {28'd0, m.op});
        check({tag, ".ex_valid"},   {31'd0, ex_valid},  {31'd0, m.valid});
        check({tag, ".ex_rd"},      {27'd0, ex_rd},     {27'd0, m.rd});
        check({tag, ".ctrl"},       {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
                                    {29'd0, m.rw, m.mr, m.mw});
        check({tag, ".stall"},      {31'd0, stall_if_id}, {31'd0, (load_use() && !flush)});
    endtask

    task automatic clear_inputs();
        reset = 0;  flush = 0;  id_valid = 0;
        id_pc = 0;  id_rs1_data = 0;  id_rs2_data = 0;  id_imm = 0;
        id_rs1 = 0;  id_rs2 = 0;  id_rd = 0;  id_alu_op = 0;
        id_src_a_pc = 0;  id_src_b_imm = 0;
        id_reg_write = 0;  id_mem_read = 0;  id_mem_write = 0;
        mem_rd = 0;  mem_reg_write = 0;  mem_result = 0;
        wb_rd = 0;  wb_reg_write = 0;  wb_result = 0;
    endtask

    typedef struct {
        bit [31:0] pc, rs1_data, rs2_data, imm;
        bit [4:0]  rs1, rs2;
        bit [3:0]  op;
        bit        a_pc, b_imm;
        bit [4:0]  mrd;  bit mrw;  bit [31:0] mres;
        bit [4:0]  wrd;  bit wrw;  bit [31:0] wres;
        bit [31:0] exp_a, exp_b, exp_st;
    } vec_t;

    vec_t vt[6];

    initial begin
        m = '{default: 0};
        clear_inputs();

        // Reset with busy ID and bypass inputs.
        reset = 1;  id_valid = 1;  id_pc = 32'h40;  id_rs1_data = 32'h11;  id_rs2_data = 32'h22;
        id_imm = 32'h33;  id_rs1 = 1;  id_rs2 = 2;  id_rd = 3;  id_alu_op = 4'b0111;
        id_src_a_pc = 1;  id_src_b_imm = 1;  id_reg_write = 1;  id_mem_read = 1;  id_mem_write = 1;
        mem_rd = 1;  mem_reg_write = 1;  mem_result = 32'hEE;  wb_rd = 2;  wb_reg_write = 1;  wb_result = 32'hFF;
        tick();  tick();
        #1;
        check("rst.ex_valid", {31'd0, ex_valid}, 0);
        check("rst.Operation", {28'd0, Operation}, 0);
        check("rst.SrcA", SrcA, 0);
        check("rst.SrcB", SrcB, 0);
        check("rst.stall", {31'd0, stall_if_id}, 0);
        clear_inputs();

        // ADDI x5,x1,7
        id_valid = 1;  id_rs1 = 1;  id_rs1_data = 10;  id_imm = 7;  id_alu_op = 4'b0011;
        id_src_b_imm = 1;  id_rd = 5;  id_reg_write = 1;
        tick();  clear_inputs();  #1;
        check("addi.SrcA", SrcA, 10);
        check("addi.SrcB", SrcB, 7);
        check("addi.Operation", {28'd0, Operation}, 32'h3);
        check("addi.ex_rd", {27'd0, ex_rd}, 5);

        // Forward priority on rs1=x3, then rs1=x0.
        id_valid = 1;  id_rs1 = 3;  id_rs1_data = 32'h55;  id_rd = 9;  id_reg_write = 1;
        tick();  clear_inputs();
        mem_rd = 3;  mem_reg_write = 1;  mem_result = 32'hAA;
        wb_rd = 3;  wb_reg_write = 1;  wb_result = 32'hBB;
        #1;  check("fwd.mem_over_wb", SrcA, 32'hAA);
        mem_reg_write = 0;
        #1;  check("fwd.wb_only", SrcA, 32'hBB);
        mem_reg_write = 1;  mem_rd = 0;  wb_rd = 0;
        id_valid = 1;  id_rs1 = 0;  id_rs1_data = 32'h55;  id_rd = 9;
        tick();  id_valid = 0;  #1;
        check("fwd.x0_never", SrcA, 32'h55);
        clear_inputs();

        // LW x4 followed by ADD x6,x4,x2.
        id_valid = 1;  id_rs1 = 1;  id_rd = 4;  id_mem_read = 1;  id_reg_write = 1;
        id_src_b_imm = 1;  id_imm = 4;  id_alu_op = 4'b0011;
        tick();
        id_rs1 = 4;  id_rs2 = 2;  id_rd = 6;  id_mem_read = 0;  id_src_b_imm = 0;
        id_rs1_data = 32'h999;  id_rs2_data = 5;
        #1;  check("lu.stall_first", {31'd0, stall_if_id}, 1);
        tick();
        check("lu.bubble_valid", {31'd0, ex_valid}, 0);
        check("lu.bubble_rw", {31'd0, ex_reg_write}, 0);
        check("lu.stall_once", {31'd0, stall_if_id}, 0);
        tick();
        id_valid = 0;  wb_rd = 4;  wb_reg_write = 1;  wb_result = 32'h777;
        #1;
        check("lu.add_srca_wb", SrcA, 32'h777);
        check("lu.add_srcb", SrcB, 5);
        check("lu.add_rd", {27'd0, ex_rd}, 6);
        check("lu.no_stall", {31'd0, stall_if_id}, 0);
        clear_inputs();

        // Load-use hazard together with flush.
        id_valid = 1;  id_rs1 = 1;  id_rd = 8;  id_mem_read = 1;  id_reg_write = 1;
        tick();
        id_rs1 = 8;  id_rd = 10;  id_mem_read = 0;  id_mem_write = 1;  id_reg_write = 1;
        id_alu_op = 4'b0100;  flush = 1;
        #1;  check("lf.stall", {31'd0, stall_if_id}, 0);
        tick();
        check("lf.ex_valid", {31'd0, ex_valid}, 0);
        check("lf.ex_reg_write", {31'd0, ex_reg_write}, 0);
        check("lf.ex_mem_write", {31'd0, ex_mem_write}, 0);
        check("lf.Operation", {28'd0, Operation}, 0);
        clear_inputs();

        // SW x7: immediate on SrcB, forwarded store data.
        id_valid = 1;  id_rs1 = 1;  id_rs2 = 7;  id_rs2_data = 32'h50;  id_imm = 8;
        id_src_b_imm = 1;  id_mem_write = 1;  id_alu_op = 4'b0011;
        tick();  clear_inputs();
        mem_rd = 7;  mem_reg_write = 1;  mem_result = 32'h1234;
        #1;
        check("sw.SrcB", SrcB, 8);
        check("sw.store", ex_store_data, 32'h1234);
        clear_inputs();

        // Forwarding vector table.
        vt[0] = '{32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd2, 4'b0011, 1'b1, 1'b1,
                  5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h100, 32'h4, 32'h22};
        vt[1] = '{32'h104, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 4'b0100, 1'b0, 1'b0,
                  5'd2, 1'b1, 32'hA2, 5'd1, 1'b1, 32'hB1, 32'hB1, 32'hA2, 32'hA2};
        vt[2] = '{32'h108, 32'h11, 32'h22, 32'h0, 5'd5, 5'd5, 4'b0001, 1'b0, 1'b0,
                  5'd5, 1'b0, 32'hA5, 5'd5, 1'b1, 32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE};
        vt[3] = '{32'h10C, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 4'b0010, 1'b0, 1'b0,
                  5'd0, 1'b1, 32'hA0, 5'd0, 1'b1, 32'hB0, 32'h33, 32'h44, 32'h44};
        vt[4] = '{32'h110, 32'h99, 32'h88, 32'hFFFF_FFF0, 5'd9, 5'd10, 4'b1001, 1'b0, 1'b1,
                  5'd10, 1'b1, 32'hDEAD, 5'd9, 1'b0, 32'hBEEF, 32'h99, 32'hFFFF_FFF0, 32'hDEAD};
        vt[5] = '{32'h200, 32'h77, 32'h66, 32'h0, 5'd31, 5'd31, 4'b1101, 1'b1, 1'b0,
                  5'd31, 1'b1, 32'h1, 5'd31, 1'b1, 32'h2, 32'h200, 32'h1, 32'h1};
        for (int i = 0; i < 6; i++) begin
            id_valid = 1;  id_pc = vt[i].pc;  id_rs1_data = vt[i].rs1_data;
            id_rs2_data = vt[i].rs2_data;  id_imm = vt[i].imm;  id_rs1 = vt[i].rs1;
            id_rs2 = vt[i].rs2;  id_rd = 5'(i + 1);  id_alu_op = vt[i].op;
            id_src_a_pc = vt[i].a_pc;  id_src_b_imm = vt[i].b_imm;  id_reg_write = 1;
            tick();  clear_inputs();
            mem_rd = vt[i].mrd;  mem_reg_write = vt[i].mrw;  mem_result = vt[i].mres;
            wb_rd = vt[i].wrd;  wb_reg_write = vt[i].wrw;  wb_result = vt[i].wres;
            #1;
            check($sformatf("vec%0d.SrcA", i), SrcA, vt[i].exp_a);
            check($sformatf("vec%0d.SrcB", i), SrcB, vt[i].exp_b);
            check($sformatf("vec%0d.store", i), ex_store_data, vt[i].exp_st);
            check($sformatf("vec%0d.Operation", i), {28'd0, Operation}, {28'd0, vt[i].op});
        end
        clear_inputs();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_pc = $urandom;  id_rs1_data = $urandom;  id_rs2_data = $urandom;  id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 7));  id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));  id_alu_op = 4'($urandom_range(0, 13));
            id_src_a_pc = 1'($urandom);  id_src_b_imm = 1'($urandom);
            id_reg_write = 1'($urandom);  id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 7));  mem_reg_write = 1'($urandom);  mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7));  wb_reg_write = 1'($urandom);  wb_result = $urandom;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
